// File: rtl/dtm_dot_accum_pkg.sv
// Shared constants and state encoding for the dot-product accumulator and its
// 4x4 Dadda multiplier.
package dtm_dot_accum_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/dtm_dot_accum_dtm_4bit.sv
// 4x4 unsigned Dadda tree multiplier: 16 partial products reduced to two rows
// (heights 4 -> 3 -> 2), then a single carry-propagate add.
module DTM_4bit
  import dtm_dot_accum_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] p_o
);

  // pp[i][j] = a[j] & b[i], weight i+j
  logic [3:0][3:0] pp;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a_i[j] & b_i[i];
      end
    end
  end

  // Stage 1: reduce max column height from 4 to 3.
  logic s3a, c4a, s4a, c5a;
  assign s3a = pp[0][3] ^ pp[1][2];
  assign c4a = pp[0][3] & pp[1][2];
  assign s4a = pp[1][3] ^ pp[2][2];
  assign c5a = pp[1][3] & pp[2][2];

  // Stage 2: reduce max column height from 3 to 2.
  logic s2b, c3b, s3b, c4b, s4b, c5b, s5b, c6b;
  assign s2b = pp[0][2] ^ pp[1][1];
  assign c3b = pp[0][2] & pp[1][1];
  assign s3b = s3a ^ pp[2][1] ^ pp[3][0];
  assign c4b = (s3a & pp[2][1]) | (s3a & pp[3][0]) | (pp[2][1] & pp[3][0]);
  assign s4b = s4a ^ pp[3][1] ^ c4a;
  assign c5b = (s4a & pp[3][1]) | (s4a & c4a) | (pp[3][1] & c4a);
  assign s5b = pp[2][3] ^ pp[3][2] ^ c5a;
  assign c6b = (pp[2][3] & pp[3][2]) | (pp[2][3] & c5a) | (pp[3][2] & c5a);

  logic [PROD_W-1:0] row_x, row_y;
  assign row_x = {1'b0, pp[3][3], s5b, s4b, s3b, s2b, pp[0][1], pp[0][0]};
  assign row_y = {1'b0, c6b, c5b, c4b, c3b, pp[2][0], pp[1][0], 1'b0};
  assign p_o   = row_x + row_y;

endmodule

// File: rtl/dtm_dot_accum.sv
// Streams LEN operand pairs through a DTM_4bit multiplier, accumulates the
// products and presents the dot product on a held valid/ready output.
module dtm_dot_accum
  import dtm_dot_accum_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  localparam int              CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OP_W-1:0]     s1_a_q, s1_b_q;
  logic                s1_valid_q;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   s2_prod_q;
  logic                s2_valid_q;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                in_xfer, out_xfer;

  // in_ready is gated by rst so no pair is offered a handshake during reset.
  assign in_ready  = !rst && (state_q == ACC) && (cnt_q < LEN_C);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign busy      = (state_q != ACC) || s1_valid_q || s2_valid_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  DTM_4bit u_dtm (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (prod)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (s2_valid_q) acc_d = acc_q + ACC_W'(s2_prod_q);

    unique case (state_q)
      ACC: begin
        if (in_xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == LEN_C) state_d = DRAIN;
        end
      end
      // Leaving only once both stages are empty guarantees the last add is in acc_q.
      DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = DONE;
      DONE: begin
        if (out_xfer) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all registers, datapath included, clear on reset so a partial vector never leaks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACC;
      cnt_q      <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_valid_q <= 1'b0;
      s2_prod_q  <= '0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      s1_valid_q <= in_xfer;
      s2_valid_q <= s1_valid_q;
      if (in_xfer) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
      end
      if (s1_valid_q) s2_prod_q <= prod;
    end
  end

endmodule

// File: tb/tb_dtm_dot_accum.sv
// Directed bench: a LEN=8 instance driven from a vector table plus reset and
// backpressure sequences, and a LEN=1 instance with out_ready tied high.
module tb_dtm_dot_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  in_a, in_b;
  logic [10:0] out_sum;

  logic        r1_in_valid, r1_in_ready, r1_out_valid, r1_busy;
  logic [3:0]  r1_in_a, r1_in_b;
  logic [7:0]  r1_out_sum;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtm_dot_accum #(.LEN(8), .ACC_W(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy)
  );

  dtm_dot_accum #(.LEN(1), .ACC_W(8)) dut_len1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r1_in_valid),
    .in_ready  (r1_in_ready),
    .in_a      (r1_in_a),
    .in_b      (r1_in_b),
    .out_valid (r1_out_valid),
    .out_ready (1'b1),
    .out_sum   (r1_out_sum),
    .busy      (r1_busy)
  );

  typedef struct {
    logic [7:0][3:0] a;
    logic [7:0][3:0] b;
    bit              gap;
    int              hold;
    int              exp_sum;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sends one vector, pushes junk after the 8th pair to confirm in_ready has
  // dropped, then checks the result, optional backpressure and the handshake.
  task automatic run_vec(input vec_t v, input string tag);
    int idx, extra, t_last, guard;
    bit got;
    idx = 0; extra = 0; t_last = 0; guard = 0; got = 0;
    while (!got && guard < 200) begin
      @(posedge clk); #1;
      if (idx < 8) begin
        in_valid = v.gap ? ((guard % 2) == 0) : 1'b1;
        in_a = v.a[idx];
        in_b = v.b[idx];
      end else begin
        in_valid = 1'b1;
        in_a = 4'hF;
        in_b = 4'hF;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (idx < 8) begin
          idx++;
          t_last = cyc + 1;
        end else begin
          extra++;
        end
      end
      if (out_valid) got = 1'b1;
      guard++;
    end
    check({tag, " out_valid_seen"}, longint'(got), 1);
    check({tag, " transfers"}, idx, 8);
    check({tag, " extra_transfers"}, extra, 0);
    check({tag, " latency"}, cyc - t_last, 3);
    check({tag, " sum"}, out_sum, v.exp_sum);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_sum"}, out_sum, v.exp_sum);
      check({tag, " hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check({tag, " post_valid"}, out_valid, 0);
    check({tag, " post_in_ready"}, in_ready, 1);
    check({tag, " post_sum"}, out_sum, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, guard;
    vec_t rv;
    int r1_a[4]   = '{7, 15, 0, 4};
    int r1_b[4]   = '{9, 15, 9, 4};
    int r1_exp[4] = '{63, 225, 0, 16};
    int n_in, n_out, t_in, last_out_edge;

    for (int i = 0; i < 8; i++) begin
      tbl[0].a[i] = 4'(i);  tbl[0].b[i] = 4'(i);
      tbl[1].a[i] = 4'd15;  tbl[1].b[i] = 4'd15;
      tbl[2].a[i] = 4'd0;   tbl[2].b[i] = 4'd0;
      tbl[3].a[i] = 4'd3;   tbl[3].b[i] = 4'd5;
      tbl[4].a[i] = 4'd1;   tbl[4].b[i] = 4'd1;
      rv.a[i] = 4'd2;       rv.b[i] = 4'd2;
    end
    tbl[0].gap = 0; tbl[0].hold = 0; tbl[0].exp_sum = 140;
    tbl[1].gap = 0; tbl[1].hold = 0; tbl[1].exp_sum = 1800;
    tbl[2].gap = 0; tbl[2].hold = 0; tbl[2].exp_sum = 0;
    tbl[3].gap = 1; tbl[3].hold = 5; tbl[3].exp_sum = 120;
    tbl[4].gap = 0; tbl[4].hold = 0; tbl[4].exp_sum = 8;
    rv.gap = 0; rv.hold = 0; rv.exp_sum = 32;

    rst = 1'b1; in_valid = 1'b1; in_a = 4'd0; in_b = 4'd0; out_ready = 1'b0;
    r1_in_valid = 1'b0; r1_in_a = 4'd0; r1_in_b = 4'd0;
    #12;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_sum", out_sum, 0);
    check("rst busy", busy, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", in_ready, 1);
    check("idle busy", busy, 0);

    for (int k = 0; k < 5; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

    // Reset after four accepted pairs: partial sum must be discarded.
    idx = 0; guard = 0;
    while (idx < 4 && guard < 50) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      guard++;
    end
    check("midrst partial_transfers", idx, 4);
    @(posedge clk); #1;
    check("midrst busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_sum", out_sum, 0);
    check("midrst busy", busy, 0);
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec(rv, "after_rst");

    // LEN=1 with out_ready tied high: back-to-back single-pair vectors.
    n_in = 0; n_out = 0; t_in = 0; last_out_edge = -1; guard = 0;
    while (n_out < 4 && guard < 100) begin
      @(posedge clk); #1;
      r1_in_valid = (n_in < 4);
      r1_in_a = 4'(r1_a[n_in % 4]);
      r1_in_b = 4'(r1_b[n_in % 4]);
      @(negedge clk);
      if (r1_in_valid && r1_in_ready) begin
        check("len1 one_pair_per_vector", n_in - n_out, 0);
        if (last_out_edge >= 0) check("len1 restart_edge", cyc + 1, last_out_edge + 1);
        t_in = cyc + 1;
        n_in++;
      end
      if (r1_out_valid) begin
        check("len1 latency", cyc - t_in, 3);
        check("len1 sum", r1_out_sum, r1_exp[n_out]);
        last_out_edge = cyc + 1;
        n_out++;
      end
      guard++;
    end
    check("len1 outputs", n_out, 4);
    r1_in_valid = 1'b0;
    @(negedge clk);
    check("len1 idle_busy", r1_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
